// File: rtl/typing_checker_if.sv
// typing_checker_if: word load, keystroke and status/counter bundle for typing_checker
interface typing_checker_if #(
    parameter int N_LETTERS = 4,
    parameter int LW = 5,
    parameter int CNTW = 6
);
    localparam int CW = $clog2(N_LETTERS);
    logic load;
    logic [N_LETTERS*LW-1:0] cword;
    logic kr;
    logic [LW-1:0] kstrk;
    logic busy;
    logic [CW-1:0] cletter;
    logic pass;
    logic fail;
    logic [CNTW-1:0] npassed;
    logic [CNTW-1:0] nfailed;
    modport master (output load, cword, kr, kstrk,
                    input busy, cletter, pass, fail, npassed, nfailed);
    modport slave (input load, cword, kr, kstrk,
                   output busy, cletter, pass, fail, npassed, nfailed);
endinterface

// File: rtl/typing_checker.sv
// typing_checker: checks keystrokes against a latched word, counting passed/failed words
// Define TYPING_CHECKER_BACKSPACE_EN to make BKSP step back a letter and recover from FAIL.
module typing_checker #(
    parameter int N_LETTERS = 4,
    parameter int LW = 5,
    parameter int CNTW = 6,
    parameter logic [LW-1:0] BKSP = LW'(5'h1F)
) (
    input logic clk,
    input logic rst,
    typing_checker_if.slave bus
);
    localparam int CW = $clog2(N_LETTERS);
    localparam logic [CW-1:0] LAST = CW'(N_LETTERS - 1);
`ifdef TYPING_CHECKER_BACKSPACE_EN
    localparam bit BK_EN = 1'b1;
`else
    localparam bit BK_EN = 1'b0;
`endif
    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_FAIL} state_t;
    state_t state, state_n;
    logic [N_LETTERS*LW-1:0] word;
    logic kr_q, acc, hit, bk;
    logic [CW-1:0] cl, cl_n;
    logic pass_q, fail_q, pass_n, fail_n;
    logic [CNTW-1:0] np, nf, np_n, nf_n;
    // a keystroke counts only on the rising edge of the release level
    assign acc = bus.kr & ~kr_q;
    assign hit = bus.kstrk == word[int'(cl)*LW +: LW];
    assign bk = BK_EN && (bus.kstrk == BKSP);
    always_comb begin
        state_n = state;
        cl_n = cl;
        pass_n = 1'b0;
        fail_n = 1'b0;
        np_n = np;
        nf_n = nf;
        if (bus.load) begin
            state_n = S_CHECK;
            cl_n = '0;
        end else if (acc && state == S_CHECK) begin
            if (bk) cl_n = (cl == '0) ? cl : cl - 1'b1;
            else if (hit && cl == LAST) begin
                state_n = S_IDLE;
                cl_n = '0;
                pass_n = 1'b1;
                np_n = &np ? np : np + 1'b1;
            end else if (hit) cl_n = cl + 1'b1;
            else begin
                state_n = S_FAIL;
                fail_n = 1'b1;
                nf_n = &nf ? nf : nf + 1'b1;
            end
        end else if (acc && state == S_FAIL && bk) state_n = S_CHECK;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cl <= '0;
            pass_q <= 1'b0;
            fail_q <= 1'b0;
            np <= '0;
            nf <= '0;
            kr_q <= 1'b0;
            word <= '0;
        end else begin
            state <= state_n;
            cl <= cl_n;
            pass_q <= pass_n;
            fail_q <= fail_n;
            np <= np_n;
            nf <= nf_n;
            kr_q <= bus.kr;
            word <= bus.load ? bus.cword : word;
        end
    end
    assign bus.busy = state == S_CHECK;
    assign bus.cletter = cl;
    assign bus.pass = pass_q;
    assign bus.fail = fail_q;
    assign bus.npassed = np;
    assign bus.nfailed = nf;
endmodule

// File: tb/tb_typing_checker.sv
// tb_typing_checker: directed self-checking bench for typing_checker (N_LETTERS=4, LW=5, CNTW=6)
module tb_typing_checker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int passed = 0;
    localparam logic [19:0] W = {5'd4, 5'd3, 5'd2, 5'd1};
    typing_checker_if #(.N_LETTERS(4), .LW(5), .CNTW(6)) b ();
    typing_checker #(.N_LETTERS(4), .LW(5), .CNTW(6), .BKSP(5'h1F)) dut (
        .clk(clk), .rst(rst), .bus(b)
    );
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic load_word(input logic [19:0] w);
        @(negedge clk);
        b.load = 1'b1;
        b.cword = w;
        @(negedge clk);
        b.load = 1'b0;
    endtask

    // one kr 0->1->0 pulse; returns at the negedge right after the accepting edge
    task automatic key(input logic [4:0] k);
        @(negedge clk);
        b.kr = 1'b1;
        b.kstrk = k;
        @(negedge clk);
        b.kr = 1'b0;
        chk("pass_fail_excl", {31'b0, b.pass & b.fail}, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        b.load = 1'b0;
        b.cword = '0;
        b.kr = 1'b0;
        b.kstrk = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", b.busy, 0);
        chk("rst_cletter", b.cletter, 0);
        chk("rst_pass", b.pass, 0);
        chk("rst_fail", b.fail, 0);
        chk("rst_npassed", b.npassed, 0);
        chk("rst_nfailed", b.nfailed, 0);
        key(5'd1);
        chk("idle_ignores_key", b.cletter, 0);

        load_word(W);
        b.cword = 20'h0;
        chk("load_busy", b.busy, 1);
        chk("load_cletter", b.cletter, 0);
        key(5'd1); chk("w1_cl1", b.cletter, 1);
        key(5'd2); chk("w1_cl2", b.cletter, 2);
        key(5'd3); chk("w1_cl3", b.cletter, 3);
        chk("w1_no_pass_early", b.pass, 0);
        key(5'd4);
        chk("w1_pass", b.pass, 1);
        chk("w1_cl0", b.cletter, 0);
        chk("w1_idle", b.busy, 0);
        chk("w1_npassed", b.npassed, 1);
        @(negedge clk);
        chk("w1_pass_one_cycle", b.pass, 0);

        load_word(W);
        key(5'd1);
        key(5'd7);
        chk("w2_fail", b.fail, 1);
        chk("w2_cl_hold", b.cletter, 1);
        chk("w2_nfailed", b.nfailed, 1);
        chk("w2_not_busy", b.busy, 0);
        @(negedge clk);
        chk("w2_fail_one_cycle", b.fail, 0);
        key(5'd2);
        chk("w2_ignored_cl", b.cletter, 1);
        chk("w2_ignored_pass", b.pass, 0);
        chk("w2_npassed", b.npassed, 1);

        load_word(W);
        @(negedge clk);
        b.kr = 1'b1;
        b.kstrk = 5'd1;
        repeat (10) @(negedge clk);
        b.kr = 1'b0;
        chk("held_once", b.cletter, 1);
        @(negedge clk);
        chk("fall_nothing", b.cletter, 1);

        load_word(W);
        key(5'd1);
        key(5'd2);
        do_reset();
        chk("midrst_cl", b.cletter, 0);
        chk("midrst_np", b.npassed, 0);
        chk("midrst_nf", b.nfailed, 0);
        chk("midrst_pass", b.pass, 0);
        chk("midrst_fail", b.fail, 0);
        chk("midrst_busy", b.busy, 0);
        load_word(W);
        chk("postrst_cl", b.cletter, 0);
        chk("postrst_np", b.npassed, 0);
        @(negedge clk);
        b.load = 1'b1;
        b.cword = W;
        b.kr = 1'b1;
        b.kstrk = 5'd1;
        @(negedge clk);
        b.load = 1'b0;
        b.kr = 1'b0;
        chk("load_wins_cl", b.cletter, 0);
        chk("load_wins_busy", b.busy, 1);
        key(5'd1);
        chk("after_drop_cl", b.cletter, 1);

        do_reset();
        load_word(W);
        key(5'd1);
        key(5'd9);
        chk("bk_fail", b.fail, 1);
        key(5'h1F);
`ifdef TYPING_CHECKER_BACKSPACE_EN
        chk("bk_recover_busy", b.busy, 1);
        chk("bk_recover_cl", b.cletter, 1);
        key(5'd2);
        key(5'd3);
        key(5'd4);
        chk("bk_pass", b.pass, 1);
        chk("bk_npassed", b.npassed, 1);
        chk("bk_nfailed", b.nfailed, 1);
        load_word(W);
        key(5'd1);
        key(5'd2);
        key(5'h1F);
        chk("bk_step_back", b.cletter, 1);
        key(5'h1F);
        chk("bk_to_zero", b.cletter, 0);
        key(5'h1F);
        chk("bk_floor", b.cletter, 0);
        chk("bk_no_fail_count", b.nfailed, 1);
`else
        chk("nobk_stay_fail", b.busy, 0);
        key(5'd2);
        key(5'd3);
        key(5'd4);
        chk("nobk_no_pass", b.pass, 0);
        chk("nobk_npassed", b.npassed, 0);
        chk("nobk_nfailed", b.nfailed, 1);
`endif

        do_reset();
        repeat (63) begin
            load_word(W);
            key(5'd1); key(5'd2); key(5'd3); key(5'd4);
        end
        chk("np_63", b.npassed, 63);
        load_word(W);
        key(5'd1); key(5'd2); key(5'd3); key(5'd4);
        chk("np_sat_pulse", b.pass, 1);
        chk("np_sat", b.npassed, 63);
        repeat (64) begin
            load_word(W);
            key(5'd7);
        end
        chk("nf_sat", b.nfailed, 63);
        chk("nf_sat_pulse", b.fail, 1);
        chk("np_kept", b.npassed, 63);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
